// File: rtl/arm_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package arm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_WBACK = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    localparam logic [1:0] AM_DA = 2'b00;
    localparam logic [1:0] AM_IA = 2'b01;
    localparam logic [1:0] AM_DB = 2'b10;
    localparam logic [1:0] AM_IB = 2'b11;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam int          NUM_REGS   = 16;

    // Byte span covered by n word transfers.
    function automatic logic [31:0] block_bytes(input logic [4:0] n);
        return {25'd0, n, 2'b00};
    endfunction

endpackage

// File: rtl/reg_list_scan.sv
// Combinational register-list scan: lowest set index, any-set flag and popcount.
module reg_list_scan
    import arm_pkg::*;
(
    input  logic [NUM_REGS-1:0] list,
    output logic [3:0]          lowest,
    output logic                any_set,
    output logic [4:0]          count
);

    // Walking downwards leaves the lowest set index as the final assignment.
    always_comb begin
        lowest = '0;
        count  = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (list[i]) begin
                lowest = 4'(i);
            end
            count = count + 5'(list[i]);
        end
    end

    assign any_set = |list;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list lowest-first, one word access per step.
// Define LDMSTM_BASE_WB_EN to honour base_wb and enable the WBACK state.
module ldm_stm_sequencer
    import arm_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic [1:0]  am,
    input  logic        base_wb,
    input  logic [3:0]  base_reg,
    input  logic [31:0] base_addr,
    input  logic [15:0] reg_list,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [4:0]  rf_read_reg,
    input  logic [31:0] rf_read_data,
    output logic        rf_regwrite,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data
);

    localparam logic [NUM_REGS-1:0] LIST_BIT0 = 1;

    seq_state_t          state;
    logic [NUM_REGS-1:0] list_q;
    logic                is_load_q;
`ifdef LDMSTM_BASE_WB_EN
    logic [31:0]         final_base_q;
    logic [3:0]          base_reg_q;
    logic                do_wb_q;
    logic                wb_req;
`endif

    logic [3:0]          in_lowest;
    logic [3:0]          cur_reg;
    logic                in_any;
    logic                cur_any;
    logic [4:0]          in_count;
    logic [4:0]          cur_count;
    logic [31:0]         aligned_base;
    logic [31:0]         span;
    logic [31:0]         start_addr;
    logic [31:0]         final_base;
    logic [NUM_REGS-1:0] list_next;
    logic                xfer_done;
    logic                unused_sigs;

    reg_list_scan u_scan_in (
        .list    (reg_list),
        .lowest  (in_lowest),
        .any_set (in_any),
        .count   (in_count)
    );

    reg_list_scan u_scan_cur (
        .list    (list_q),
        .lowest  (cur_reg),
        .any_set (cur_any),
        .count   (cur_count)
    );

    assign aligned_base = {base_addr[31:2], 2'b00};
    assign span         = block_bytes(in_count);
    assign list_next    = list_q & ~(LIST_BIT0 << cur_reg);
    assign xfer_done    = mem_req && mem_ready;
    assign mem_wdata    = rf_read_data;

`ifdef LDMSTM_BASE_WB_EN
    // A loaded base register keeps its memory value, so writeback is dropped.
    assign wb_req = base_wb && !(is_load && reg_list[base_reg]);
`endif

    // The lowest register always takes the lowest address of the block.
    always_comb begin
        start_addr = aligned_base - span;
        final_base = aligned_base - span;
        case (am)
            AM_IA: begin
                start_addr = aligned_base;
                final_base = aligned_base + span;
            end
            AM_IB: begin
                start_addr = aligned_base + WORD_BYTES;
                final_base = aligned_base + span;
            end
            AM_DA: start_addr = aligned_base - span + WORD_BYTES;
            default: start_addr = aligned_base - span;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            list_q    <= '0;
            is_load_q <= 1'b0;
`ifdef LDMSTM_BASE_WB_EN
            final_base_q <= '0;
            base_reg_q   <= '0;
            do_wb_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        list_q    <= reg_list;
                        is_load_q <= is_load;
                        busy      <= 1'b1;
`ifdef LDMSTM_BASE_WB_EN
                        final_base_q <= final_base;
                        base_reg_q   <= base_reg;
                        do_wb_q      <= wb_req;
`endif
                        if (in_any) begin
                            state    <= S_XFER;
                            mem_req  <= 1'b1;
                            mem_we   <= !is_load;
                            mem_addr <= start_addr;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    if (xfer_done) begin
                        list_q   <= list_next;
                        mem_addr <= mem_addr + WORD_BYTES;
                        if (list_next == '0) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
`ifdef LDMSTM_BASE_WB_EN
                            if (do_wb_q) begin
                                state <= S_WBACK;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
`else
                            state <= S_DONE;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LDMSTM_BASE_WB_EN
                S_WBACK: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Load writes land in the same cycle the memory access completes.
    always_comb begin
        rf_read_reg   = '0;
        rf_regwrite   = 1'b0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        if (state == S_XFER) begin
            rf_read_reg   = {1'b0, cur_reg};
            rf_write_reg  = {1'b0, cur_reg};
            rf_write_data = mem_rdata;
            rf_regwrite   = is_load_q && xfer_done;
        end
`ifdef LDMSTM_BASE_WB_EN
        if (state == S_WBACK) begin
            rf_regwrite   = 1'b1;
            rf_write_reg  = {1'b0, base_reg_q};
            rf_write_data = final_base_q;
        end
`endif
    end

    assign unused_sigs = ^{in_lowest, cur_any, cur_count, base_addr[1:0]
`ifndef LDMSTM_BASE_WB_EN
                           , base_wb, base_reg, final_base
`endif
                          };

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: vector table plus access/writeback scoreboard.
module tb_ldm_stm_sequencer;
    import arm_pkg::*;

`ifdef LDMSTM_BASE_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif
    localparam logic [31:0] MEM_KEY = 32'h5A5A_0000;
    localparam logic [31:0] RF_KEY  = 32'hC0DE_0000;
    localparam int          NVEC    = 8;

    typedef struct {
        logic        ld;
        logic [1:0]  am;
        logic        wb;
        logic [3:0]  breg;
        logic [31:0] base;
        logic [15:0] list;
        int          stall;
        logic [31:0] first;
        logic [31:0] fin;
        logic        wb_ok;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  rnum;
        logic        ld;
    } acc_t;

    typedef struct {
        logic [4:0]  rnum;
        logic [31:0] data;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset, start, is_load, base_wb, mem_ready;
    logic [1:0]  am;
    logic [3:0]  base_reg;
    logic [31:0] base_addr, mem_rdata, rf_read_data;
    logic [15:0] reg_list;
    logic        busy, done, mem_req, mem_we, rf_regwrite;
    logic [31:0] mem_addr, mem_wdata, rf_write_data;
    logic [4:0]  rf_read_reg, rf_write_reg;

    vec_t vecs[NVEC];
    acc_t acc_q[$];
    wb_t  wb_q[$];
    acc_t mon_acc;
    wb_t  mon_wb;

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;
    int done_cnt = 0;
    int done_cycle = 0;
    int start_cycle = 0;
    int stall_cycles = 0;
    int wait_cnt = 0;
    int exp_lat = 0;
    int cur_vec = -1;

    ldm_stm_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .is_load       (is_load),
        .am            (am),
        .base_wb       (base_wb),
        .base_reg      (base_reg),
        .base_addr     (base_addr),
        .reg_list      (reg_list),
        .busy          (busy),
        .done          (done),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .rf_read_reg   (rf_read_reg),
        .rf_read_data  (rf_read_data),
        .rf_regwrite   (rf_regwrite),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    // Memory and register-file models with address/index-dependent data.
    assign mem_rdata    = mem_addr ^ MEM_KEY;
    assign rf_read_data = RF_KEY | {27'd0, rf_read_reg};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", name, cur_vec, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [1:0] mode, input logic wb,
                                input logic [3:0] breg, input logic [31:0] base,
                                input logic [15:0] list, input int stall,
                                input logic [31:0] first, input logic [31:0] fin,
                                input logic wb_ok);
        vec_t v;
        v.ld = ld; v.am = mode; v.wb = wb; v.breg = breg; v.base = base;
        v.list = list; v.stall = stall; v.first = first; v.fin = fin; v.wb_ok = wb_ok;
        return v;
    endfunction

    // Memory responder (stall_cycles wait cycles per access) and output monitor.
    always begin
        @(negedge clock);
        if (mem_req === 1'b1) begin
            if (wait_cnt >= stall_cycles) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
        #1;
        if (mem_req === 1'b1 && mem_ready) begin
            if (acc_q.size() == 0) begin
                check("unexpected_access", mem_req, 1'b0);
            end else begin
                mon_acc = acc_q.pop_front();
                check("mem_addr", mem_addr, mon_acc.addr);
                check("mem_we", mem_we, !mon_acc.ld);
                check("rf_read_reg", rf_read_reg, mon_acc.rnum);
                if (mon_acc.ld) begin
                    check("ld_regwrite", rf_regwrite, 1'b1);
                    check("ld_write_reg", rf_write_reg, mon_acc.rnum);
                    check("ld_write_data", rf_write_data, mon_acc.addr ^ MEM_KEY);
                end else begin
                    check("st_wdata", mem_wdata, RF_KEY | mon_acc.rnum);
                    check("st_no_regwrite", rf_regwrite, 1'b0);
                end
            end
        end else if (mem_req === 1'b1) begin
            if (acc_q.size() > 0) begin
                check("stall_addr", mem_addr, acc_q[0].addr);
                check("stall_we", mem_we, !acc_q[0].ld);
                check("stall_no_regwrite", rf_regwrite, 1'b0);
                if (!acc_q[0].ld) check("stall_wdata", mem_wdata, RF_KEY | acc_q[0].rnum);
            end
        end else if (rf_regwrite === 1'b1) begin
            if (wb_q.size() == 0) begin
                check("unexpected_regwrite", rf_regwrite, 1'b0);
            end else begin
                mon_wb = wb_q.pop_front();
                check("wb_reg", rf_write_reg, mon_wb.rnum);
                check("wb_data", rf_write_data, mon_wb.data);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cycle = cycle;
            check("done_no_regwrite", rf_regwrite, 1'b0);
        end
    end

    // Pushes expected accesses/writeback, then pulses start for one cycle.
    task automatic applyStimulus(input vec_t v);
        int   k;
        bit   wb_exp;
        acc_t a;
        wb_t  w;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (v.list[i]) begin
                a.addr = v.first + 32'(4 * k);
                a.rnum = 5'(i);
                a.ld   = v.ld;
                acc_q.push_back(a);
                k++;
            end
        end
        wb_exp = WB_EN && v.wb && v.wb_ok && (k > 0);
        if (wb_exp) begin
            w.rnum = {1'b0, v.breg};
            w.data = v.fin;
            wb_q.push_back(w);
        end
        exp_lat      = 1 + k * (v.stall + 1) + (wb_exp ? 1 : 0) + 1;
        stall_cycles = v.stall;
        done_cnt     = 0;
        @(negedge clock);
        start     = 1'b1;
        is_load   = v.ld;
        am        = v.am;
        base_wb   = v.wb;
        base_reg  = v.breg;
        base_addr = v.base;
        reg_list  = v.list;
        start_cycle = cycle;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic checkOutput();
        for (int k = 0; k < 400 && done_cnt == 0; k++) @(negedge clock);
        check("done_count", 32'(done_cnt), 32'd1);
        check("latency", 32'(done_cycle - start_cycle + 1), 32'(exp_lat));
        check("accesses_left", 32'(acc_q.size()), 32'd0);
        check("writebacks_left", 32'(wb_q.size()), 32'd0);
        check("idle_busy", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        acc_q.delete();
        wb_q.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; am = AM_IA; base_wb = 1'b0;
        base_reg = '0; base_addr = '0; reg_list = '0; mem_ready = 1'b0;

        //                ld    am     wb    breg   base           list      st first          final          ok
        vecs[0] = mk(1'b1, AM_IA, 1'b1, 4'd13, 32'h0000_1000, 16'h000E, 0, 32'h0000_1000, 32'h0000_100C, 1'b1);
        vecs[1] = mk(1'b0, AM_DB, 1'b1, 4'd4,  32'h0000_2000, 16'h8003, 2, 32'h0000_1FF4, 32'h0000_1FF4, 1'b1);
        vecs[2] = mk(1'b1, AM_IB, 1'b1, 4'd2,  32'h0000_3000, 16'h0004, 0, 32'h0000_3004, 32'h0000_3004, 1'b0);
        vecs[3] = mk(1'b1, AM_IA, 1'b1, 4'd0,  32'h0000_4000, 16'h0000, 0, 32'h0000_0000, 32'h0000_4000, 1'b1);
        vecs[4] = mk(1'b0, AM_DA, 1'b1, 4'd7,  32'h0000_0004, 16'h0007, 1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b1);
        vecs[5] = mk(1'b0, AM_IA, 1'b0, 4'd3,  32'h0000_1003, 16'h0101, 0, 32'h0000_1000, 32'h0000_1008, 1'b1);
        vecs[6] = mk(1'b1, AM_DA, 1'b1, 4'd1,  32'h0000_0100, 16'hFFFF, 0, 32'h0000_00C4, 32'h0000_00C0, 1'b0);
        vecs[7] = mk(1'b0, AM_IB, 1'b1, 4'd15, 32'h0000_8000, 16'h8000, 1, 32'h0000_8004, 32'h0000_8004, 1'b1);

        repeat (3) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_regwrite", rf_regwrite, 1'b0);
        check("rst_read_reg", rf_read_reg, 5'd0);
        check("rst_write_reg", rf_write_reg, 5'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cur_vec = i;
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // A second start while busy must be dropped, not queued.
        cur_vec = 8;
        applyStimulus(vecs[1]);
        @(negedge clock);
        start = 1'b1; is_load = 1'b1; reg_list = 16'hFFFF; am = AM_IA; base_addr = 32'h0;
        @(negedge clock);
        start = 1'b0;
        checkOutput();
        repeat (3) begin
            @(negedge clock);
            check("no_queued_start", mem_req, 1'b0);
        end

        // Reset during the second transfer cycle aborts without a done pulse.
        cur_vec = 9;
        applyStimulus(mk(1'b1, AM_IA, 1'b1, 4'd13, 32'h0000_5000, 16'h00F0, 0,
                         32'h0000_5000, 32'h0000_5010, 1'b1));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        acc_q.delete();
        wb_q.delete();
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_regwrite", rf_regwrite, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (4) @(negedge clock);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_stays_idle", mem_req, 1'b0);

        cur_vec = 10;
        applyStimulus(vecs[0]);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
